coke_vend_ctrl: RTL and testbench
=================================

Name: coke_vend_ctrl

Overview:
Sequencing controller for the Coke vending machine. It accepts coins, accumulates credit against a fixed price, and drives the dispense handshake. It returns change or a cancelled-credit refund one coin at a time through the single shared coin-return chute. It sits between the coin acceptor / button inputs and the dispenser and change-chute datapath.

Parameters:
PRICE, 50, item price in cents; must be a multiple of 5
CREDIT_W, 7, credit register width; PRICE+20 must be < 2**CREDIT_W

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  synchronous, active-high reset
coin_in  input  3  one-cycle coin pulse, one-hot {quarter,dime,nickel} = 25/10/5 cents
cancel  input  1  one-cycle cancel/refund button pulse
sold_out  input  1  level; high = no stock
vend_done  input  1  dispenser finished, one-cycle pulse
chg_ready  input  1  change chute can accept a coin this cycle
vend_req  output  1  dispense request, level, held until vend_done
chg_valid  output  1  coin-return request
chg_type  output  2  01 nickel, 10 dime, 11 quarter; 00 when chg_valid=0
coin_reject  output  1  one-cycle pulse; inserted coin diverted to reject tray
credit  output  CREDIT_W  current credit in cents, for display
busy  output  1  high in DISPENSE or CHANGE

Behaviour:
- Reset: state=IDLE. credit, vend_req, chg_valid, chg_type, coin_reject and busy are all 0. Reset mid-operation drops credit with no refund and clears any pending handshake.
- Coin validity: exactly one bit of coin_in set. Multi-hot or zero-hot is not a coin. A multi-hot pattern pulses coin_reject the next cycle; credit is unchanged.
- States: IDLE, COLLECT, DISPENSE, CHANGE.
- IDLE:
  - Valid coin with sold_out=0: credit <= value, go to COLLECT.
  - Valid coin with sold_out=1: coin_reject pulse, stay in IDLE.
  - cancel is ignored.
- COLLECT:
  - Valid coin: credit <= credit + value.
  - When registered credit >= PRICE: go to DISPENSE on the next edge. vend_req asserts one cycle after the credit update.
  - cancel: go to CHANGE (refund path); credit is kept.
  - cancel and coin in the same cycle: cancel wins, coin is rejected.
  - sold_out rising while in COLLECT: treated as cancel.
- DISPENSE:
  - vend_req=1 and busy=1. Coins are rejected (coin_reject pulse); cancel is ignored.
  - On vend_done: vend_req <= 0, credit <= credit - PRICE.
  - Then go to IDLE if the result is 0, else to CHANGE.
  - There is no timeout.
- CHANGE:
  - chg_valid=1. chg_type = largest coin <= credit (greedy: 25, then 10, then 5).
  - On chg_valid && chg_ready (same edge): credit <= credit - value; chg_type is recomputed from the new credit the next cycle.
  - When credit reaches 0: chg_valid <= 0, go to IDLE.
  - chg_valid stays high while chg_ready=0; chg_type must not change while stalled.
  - Coins are rejected; cancel is ignored.
- Throughput: at most one change coin per cycle when chg_ready is held high.
- Width: credit never exceeds PRICE+20. Subtraction never underflows because greedy selection guarantees value <= credit.
- coin_reject is registered: it pulses the cycle after the offending coin.

Decomposition:
- Shared package coke_vend_pkg:
  - state encoding (IDLE=0, COLLECT=1, DISPENSE=2, CHANGE=3)
  - coin one-hot bit indices
  - chg_type codes
  - coin value constants (5/10/25)
- One sub-module, change_sel: combinational greedy selector mapping credit to {chg_type, coin value}. It is built from 2:1 select stages matching the existing mux datapath style.

Test Plan:
1. Exact price: coins Q, Q with chg_ready=1.
   - credit goes 25 then 50; vend_req rises the cycle after credit=50.
   - vend_done -> credit 0, IDLE; chg_valid never asserted.
2. Overpay: coins D, D, D, D, Q (65).
   - Dispense, then chg_valid with chg_type 10 then 01 (dime, nickel); credit 15 -> 5 -> 0, IDLE.
3. Cancel with stalled chute: coins Q, D, then cancel; chg_ready=0 for 3 cycles, then 1.
   - chg_type stays 11 while stalled; then 11, 10 returned; credit 35 -> 10 -> 0.
4. Coin and cancel in the same cycle during COLLECT (credit 20):
   - coin_reject pulses; refund returns 10, 10.
5. Invalid and blocked coins:
   - coin_in=3'b011 -> coin_reject, credit unchanged.
   - sold_out=1 in IDLE with coin N -> coin_reject, state stays IDLE.
   - coin during DISPENSE -> coin_reject.
6. Reset mid-CHANGE (credit 15):
   - Next cycle credit=0, chg_valid=0, vend_req=0, state IDLE; subsequent coin N gives credit 5.

Source files
------------

// File: rtl/coke_vend_pkg.sv
// Shared types and constants for the Coke vending controller.
// Coin values, one-hot coin bits, change codes and the FSM states.
package coke_vend_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COLLECT  = 2'd1,
      DISPENSE = 2'd2,
      CHANGE   = 2'd3
   } state_t;

   localparam int COIN_N = 0;
   localparam int COIN_D = 1;
   localparam int COIN_Q = 2;

   localparam logic [1:0] CHG_NONE = 2'b00;
   localparam logic [1:0] CHG_N    = 2'b01;
   localparam logic [1:0] CHG_D    = 2'b10;
   localparam logic [1:0] CHG_Q    = 2'b11;

   localparam int VAL_N = 5;
   localparam int VAL_D = 10;
   localparam int VAL_Q = 25;

endpackage

// File: rtl/change_sel.sv
// Greedy change selector: largest coin not exceeding the credit.
// Two cascaded 2:1 select stages (dime/nickel, then quarter).
module change_sel
   import coke_vend_pkg::*;
#(
   parameter int CREDIT_W = 7
) (
   input  logic [CREDIT_W-1:0] credit,
   output logic [1:0]          typ,
   output logic [CREDIT_W-1:0] value
);

   logic                ge_d;
   logic                ge_q;
   logic [1:0]          typ_lo;
   logic [CREDIT_W-1:0] val_lo;

   assign ge_d = credit >= CREDIT_W'(VAL_D);
   assign ge_q = credit >= CREDIT_W'(VAL_Q);

   assign typ_lo = ge_d ? CHG_D : CHG_N;
   assign val_lo = ge_d ? CREDIT_W'(VAL_D) : CREDIT_W'(VAL_N);

   assign typ   = ge_q ? CHG_Q : typ_lo;
   assign value = ge_q ? CREDIT_W'(VAL_Q) : val_lo;

endmodule

// File: rtl/coke_vend_ctrl.sv
// Vending sequencer: coin collection, dispense handshake and
// coin-at-a-time change/refund through the shared chute.
module coke_vend_ctrl
   import coke_vend_pkg::*;
#(
   parameter int PRICE    = 50,
   parameter int CREDIT_W = 7
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [2:0]          coin_in,
   input  logic                cancel,
   input  logic                sold_out,
   input  logic                vend_done,
   input  logic                chg_ready,
   output logic                vend_req,
   output logic                chg_valid,
   output logic [1:0]          chg_type,
   output logic                coin_reject,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy
);

   localparam logic [CREDIT_W-1:0] PRICE_W = CREDIT_W'(PRICE);

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic                reject_q, reject_d;
   logic                sold_out_q;

   logic                coin_ok;
   logic                coin_multi;
   logic                so_rise;
   logic [CREDIT_W-1:0] coin_val;
   logic [1:0]          sel_typ;
   logic [CREDIT_W-1:0] sel_val;

   assign coin_ok    = $onehot(coin_in);
   assign coin_multi = (coin_in != 3'b000) && !coin_ok;
   assign so_rise    = sold_out && !sold_out_q;

   always_comb begin
      coin_val = '0;
      if (coin_ok) begin
         unique case (1'b1)
            coin_in[COIN_N]: coin_val = CREDIT_W'(VAL_N);
            coin_in[COIN_D]: coin_val = CREDIT_W'(VAL_D);
            coin_in[COIN_Q]: coin_val = CREDIT_W'(VAL_Q);
         endcase
      end
   end

   change_sel #(
      .CREDIT_W(CREDIT_W)
   ) u_sel (
      .credit(credit_q),
      .typ   (sel_typ),
      .value (sel_val)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         credit_q   <= '0;
         reject_q   <= 1'b0;
         sold_out_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         credit_q   <= credit_d;
         reject_q   <= reject_d;
         sold_out_q <= sold_out;
      end
   end

   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      reject_d = coin_multi;
      unique case (state_q)
         IDLE: begin
            if (coin_ok) begin
               if (sold_out) begin
                  reject_d = 1'b1;
               end else begin
                  credit_d = coin_val;
                  state_d  = COLLECT;
               end
            end
         end
         COLLECT: begin
            // A reached price commits the sale ahead of cancel or coins.
            if (credit_q >= PRICE_W) begin
               state_d  = DISPENSE;
               reject_d = reject_d | coin_ok;
            end else if (cancel || so_rise) begin
               state_d  = CHANGE;
               reject_d = reject_d | coin_ok;
            end else if (coin_ok) begin
               credit_d = credit_q + coin_val;
            end
         end
         DISPENSE: begin
            reject_d = reject_d | coin_ok;
            if (vend_done) begin
               credit_d = credit_q - PRICE_W;
               state_d  = (credit_q == PRICE_W) ? IDLE : CHANGE;
            end
         end
         CHANGE: begin
            reject_d = reject_d | coin_ok;
            if (chg_ready) begin
               credit_d = credit_q - sel_val;
               if (credit_q == sel_val) state_d = IDLE;
            end
         end
      endcase
   end

   always_comb begin
      vend_req    = state_q == DISPENSE;
      chg_valid   = state_q == CHANGE;
      chg_type    = chg_valid ? sel_typ : CHG_NONE;
      busy        = vend_req || chg_valid;
      coin_reject = reject_q;
      credit      = credit_q;
   end

endmodule

// File: tb/tb_coke_vend_ctrl.sv
// Bench for coke_vend_ctrl: directed scenarios then random traffic,
// all checked against a queue-based behavioural model.
module tb_coke_vend_ctrl;

   localparam int PRICE = 50;
   localparam logic [2:0] CN = 3'b001;
   localparam logic [2:0] CD = 3'b010;
   localparam logic [2:0] CQ = 3'b100;

   logic       clk;
   logic       reset;
   logic [2:0] coin_in;
   logic       cancel;
   logic       sold_out;
   logic       vend_done;
   logic       chg_ready;
   logic       vend_req;
   logic       chg_valid;
   logic [1:0] chg_type;
   logic       coin_reject;
   logic [6:0] credit;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   int m_credit;
   bit m_collect;
   bit m_vend;
   bit m_rej;
   bit m_prev_so;
   int m_q[$];

   coke_vend_ctrl #(
      .PRICE   (PRICE),
      .CREDIT_W(7)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .coin_in    (coin_in),
      .cancel     (cancel),
      .sold_out   (sold_out),
      .vend_done  (vend_done),
      .chg_ready  (chg_ready),
      .vend_req   (vend_req),
      .chg_valid  (chg_valid),
      .chg_type   (chg_type),
      .coin_reject(coin_reject),
      .credit     (credit),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int cval(input int code);
      return (code == 3) ? 25 : (code == 2) ? 10 : (code == 1) ? 5 : 0;
   endfunction

   // Refund as a list of coins, largest first.
   task automatic fill_change(input int amount);
      int c;
      c = amount;
      while (c >= 25) begin m_q.push_back(3); c -= 25; end
      while (c >= 10) begin m_q.push_back(2); c -= 10; end
      while (c >= 5)  begin m_q.push_back(1); c -= 5;  end
   endtask

   task automatic model(input logic [2:0] c, input bit cn, input bit so,
                        input bit vd, input bit rdy, input bit rst);
      bit ok;
      bit multi;
      int v;
      bit rise;
      ok    = $onehot(c);
      multi = (c != 3'b000) && !ok;
      v     = !ok ? 0 : (c == CN) ? 5 : (c == CD) ? 10 : 25;
      rise  = so && !m_prev_so;
      if (rst) begin
         m_credit = 0; m_collect = 0; m_vend = 0;
         m_rej = 0; m_prev_so = 0;
         m_q.delete();
         return;
      end
      m_rej = multi;
      if (m_q.size() > 0) begin
         m_rej |= ok;
         if (rdy) begin
            m_credit -= cval(m_q[0]);
            void'(m_q.pop_front());
         end
      end else if (m_vend) begin
         m_rej |= ok;
         if (vd) begin
            m_vend = 0;
            m_credit -= PRICE;
            fill_change(m_credit);
         end
      end else if (m_collect) begin
         if (m_credit >= PRICE) begin
            m_collect = 0; m_vend = 1; m_rej |= ok;
         end else if (cn || rise) begin
            m_collect = 0; m_rej |= ok;
            fill_change(m_credit);
         end else if (ok) begin
            m_credit += v;
         end
      end else if (ok) begin
         if (so) m_rej = 1;
         else begin m_credit = v; m_collect = 1; end
      end
      m_prev_so = so;
   endtask

   task automatic check_all();
      int et;
      et = (m_q.size() > 0) ? m_q[0] : 0;
      check("credit", int'(credit), m_credit);
      check("vend_req", int'(vend_req), int'(m_vend));
      check("chg_valid", int'(chg_valid), int'(m_q.size() > 0));
      check("chg_type", int'(chg_type), et);
      check("coin_reject", int'(coin_reject), int'(m_rej));
      check("busy", int'(busy), int'(m_vend || m_q.size() > 0));
   endtask

   task automatic step(input logic [2:0] c, input bit cn, input bit so,
                       input bit vd, input bit rdy, input bit rst);
      coin_in = c; cancel = cn; sold_out = so;
      vend_done = vd; chg_ready = rdy; reset = rst;
      model(c, cn, so, vd, rdy, rst);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input bit rdy);
      step(3'b000, 0, 0, 0, rdy, 0);
   endtask

   initial begin
      logic [2:0] c;
      bit         so_lvl;
      int         r;
      m_q.delete();
      step(3'b000, 0, 0, 0, 0, 1);
      step(3'b000, 0, 0, 0, 0, 1);
      check("rst_credit", int'(credit), 0);
      check("rst_busy", int'(busy), 0);

      // exact price
      step(CQ, 0, 0, 0, 1, 0);
      step(CQ, 0, 0, 0, 1, 0);
      check("t1_credit50", int'(credit), 50);
      check("t1_noreq", int'(vend_req), 0);
      idle(1);
      check("t1_req", int'(vend_req), 1);
      idle(1);
      step(3'b000, 0, 0, 1, 1, 0);
      check("t1_done", int'(credit), 0);

      // overpay 65 -> dime, nickel
      for (int i = 0; i < 4; i++) step(CD, 0, 0, 0, 1, 0);
      step(CQ, 0, 0, 0, 1, 0);
      idle(1);
      step(3'b000, 0, 0, 1, 0, 0);
      check("t2_credit15", int'(credit), 15);
      check("t2_dime", int'(chg_type), 2);
      idle(1);
      check("t2_nickel", int'(chg_type), 1);
      idle(1);
      check("t2_idle", int'(chg_valid), 0);

      // cancel with stalled chute
      step(CQ, 0, 0, 0, 0, 0);
      step(CD, 0, 0, 0, 0, 0);
      step(3'b000, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) idle(0);
      check("t3_stall", int'(chg_type), 3);
      idle(1);
      check("t3_credit10", int'(credit), 10);
      idle(1);

      // coin with cancel
      step(CD, 0, 0, 0, 0, 0);
      step(CD, 0, 0, 0, 0, 0);
      step(CN, 1, 0, 0, 0, 0);
      check("t4_reject", int'(coin_reject), 1);
      check("t4_credit20", int'(credit), 20);
      idle(1);
      idle(1);

      // invalid / blocked coins
      step(3'b011, 0, 0, 0, 0, 0);
      check("t5_multi", int'(coin_reject), 1);
      step(CN, 0, 1, 0, 0, 0);
      check("t5_soldout", int'(coin_reject), 1);
      step(CQ, 0, 0, 0, 0, 0);
      step(CQ, 0, 0, 0, 0, 0);
      idle(0);
      step(CD, 0, 0, 0, 0, 0);
      check("t5_disp_rej", int'(coin_reject), 1);
      step(3'b000, 0, 0, 1, 0, 0);

      // reset mid-change
      step(CD, 0, 0, 0, 0, 0);
      step(CN, 0, 0, 0, 0, 0);
      step(3'b000, 1, 0, 0, 0, 0);
      idle(0);
      step(3'b000, 0, 0, 0, 0, 1);
      check("t6_chg", int'(chg_valid), 0);
      step(CN, 0, 0, 0, 0, 0);
      check("t6_credit5", int'(credit), 5);

      // random traffic
      so_lvl = 0;
      for (int i = 0; i < 4000; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            0: c = CN;
            1: c = CD;
            2, 3: c = CQ;
            4: c = ($urandom_range(0, 1) == 0) ? 3'b110 : 3'b111;
            default: c = 3'b000;
         endcase
         if ($urandom_range(0, 19) == 0) so_lvl = !so_lvl;
         step(c, $urandom_range(0, 9) == 0, so_lvl,
              $urandom_range(0, 3) == 0, $urandom_range(0, 4) < 3,
              $urandom_range(0, 149) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
